// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the FIFO-backed memory responder.
package mem_resp_pkg;

  // Width of the wait-state down-counter (WAIT is limited to 0..15).
  localparam int unsigned WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

endpackage

// File: rtl/resp_fifo_store.sv
// FIFO storage behind the responder: register array, pointers, occupancy and registered read data.
module resp_fifo_store #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;

  // Next storage state; rdata is zero unless this edge pops an entry.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rdata_d  = '0;
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rdata_d  = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  // Pointer, occupancy and flag registers; contents are abandoned on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Entry array has no reset; stale data is unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = rdata_q;
  assign count = count_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/mem_fifo_responder.sv
// Memory-side bus responder: wait-state FSM in front of a FIFO store, with sticky error flags.
module mem_fifo_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WAIT  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd,
  input  logic                   wr,
  input  logic [WIDTH-1:0]       wdata,
  output logic                   rdy,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   err_ovf,
  output logic                   err_unf,
  output logic                   err_both
);

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  rdy_q, rdy_d;
  logic                  err_ovf_q, err_ovf_d;
  logic                  err_unf_q, err_unf_d;
  logic                  err_both_q, err_both_d;
  logic                  push, pop;
  logic                  req_held;

  // The request line belonging to the latched op; dropping it aborts the transfer.
  assign req_held = (op_q == OP_WR) ? wr : rd;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: accept, count wait states (or abort), respond, return to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (rd || wr) state_d = BUSY;
      end
      BUSY: begin
        if (!req_held)         state_d = IDLE;
        else if (cnt_q == '0)  state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath logic: op latch, wait counter, FIFO strobes and error flags.
  always_comb begin
    op_d       = op_q;
    cnt_d      = cnt_q;
    push       = 1'b0;
    pop        = 1'b0;
    err_ovf_d  = err_ovf_q;
    err_unf_d  = err_unf_q;
    err_both_d = err_both_q;
    rdy_d      = (state_d == RESP);
    case (state_q)
      IDLE: begin
        if (rd || wr) begin
          op_d  = wr ? OP_WR : OP_RD;
          cnt_d = WAIT_CNT_W'(WAIT);
          if (rd && wr) err_both_d = 1'b1;
        end
      end
      BUSY: begin
        if (req_held && (cnt_q != '0)) cnt_d = cnt_q - 1'b1;
      end
      RESP: begin
        if (op_q == OP_WR) begin
          push = !full;
          if (full) err_ovf_d = 1'b1;
        end else begin
          pop = !empty;
          if (empty) err_unf_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Registered control outputs and latched transfer context.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= OP_RD;
      cnt_q      <= '0;
      rdy_q      <= 1'b0;
      err_ovf_q  <= 1'b0;
      err_unf_q  <= 1'b0;
      err_both_q <= 1'b0;
    end else begin
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      rdy_q      <= rdy_d;
      err_ovf_q  <= err_ovf_d;
      err_unf_q  <= err_unf_d;
      err_both_q <= err_both_d;
    end
  end

  resp_fifo_store #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_store (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign rdy      = rdy_q;
  assign err_ovf  = err_ovf_q;
  assign err_unf  = err_unf_q;
  assign err_both = err_both_q;

endmodule

// File: tb/tb_mem_fifo_responder.sv
// Bench for mem_fifo_responder: transaction-level queue model checked against the DUT every cycle.
`timescale 1ns/1ps
module tb_mem_fifo_responder;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned WAIT  = 1;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   rd;
  logic                   wr;
  logic [WIDTH-1:0]       wdata;
  logic                   rdy;
  logic [WIDTH-1:0]       rdata;
  logic [$clog2(DEPTH):0] count;
  logic                   full;
  logic                   empty;
  logic                   err_ovf;
  logic                   err_unf;
  logic                   err_both;

  always #5 clk = ~clk;

  mem_fifo_responder #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .WAIT  (WAIT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rd       (rd),
    .wr       (wr),
    .wdata    (wdata),
    .rdy      (rdy),
    .rdata    (rdata),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .err_ovf  (err_ovf),
    .err_unf  (err_unf),
    .err_both (err_both)
  );

  int n_vec = 0;
  int n_mis = 0;
  bit chk_en = 1'b0;

  // Model: FIFO contents as a queue plus the outputs expected in the current and next cycle.
  logic [WIDTH-1:0] fifo_m[$];
  logic             exp_rdy, nxt_rdy;
  logic [WIDTH-1:0] exp_rdata, nxt_rdata;
  int               exp_count, nxt_count;
  bit               exp_ovf, nxt_ovf, exp_unf, nxt_unf, exp_both, nxt_both;
  int               last_lat;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("rdy",      32'(rdy),      32'(exp_rdy));
      chk("rdata",    32'(rdata),    32'(exp_rdata));
      chk("count",    32'(count),    32'(exp_count));
      chk("full",     32'(full),     32'(exp_count == DEPTH));
      chk("empty",    32'(empty),    32'(exp_count == 0));
      chk("err_ovf",  32'(err_ovf),  32'(exp_ovf));
      chk("err_unf",  32'(err_unf),  32'(exp_unf));
      chk("err_both", 32'(err_both), 32'(exp_both));
    end
  end

  task automatic model_reset();
    fifo_m.delete();
    nxt_rdy   = 1'b0;
    nxt_rdata = '0;
    nxt_count = 0;
    nxt_ovf   = 1'b0;
    nxt_unf   = 1'b0;
    nxt_both  = 1'b0;
  endtask

  // Advance one clock and move the model's next-cycle values into the expected set.
  task automatic tick();
    @(posedge clk);
    #1;
    exp_rdy   = nxt_rdy;
    exp_rdata = nxt_rdata;
    exp_count = nxt_count;
    exp_ovf   = nxt_ovf;
    exp_unf   = nxt_unf;
    exp_both  = nxt_both;
    nxt_rdy   = 1'b0;
    nxt_rdata = '0;
  endtask

  // One bus transfer started in an IDLE cycle. stop_at selects the BUSY cycle (0..WAIT) in which
  // the request is dropped, or with by_rst the cycle (0..WAIT+1, WAIT+1 = rdy cycle) where reset hits.
  task automatic xfer(input bit w, input bit r, input logic [WIDTH-1:0] d,
                      input int stop_at, input bit by_rst);
    int cyc;
    last_lat = -1;
    rd = r;
    wr = w;
    wdata = d;
    if (w && r) nxt_both = 1'b1;
    tick();
    cyc = 1;
    for (int k = 0; k <= int'(WAIT); k++) begin
      if (rdy === 1'b1 && last_lat < 0) last_lat = cyc;
      if (stop_at == k) begin
        rd = 1'b0;
        wr = 1'b0;
        if (by_rst) begin
          rst = 1'b1;
          model_reset();
        end
        tick();
        rst = 1'b0;
        return;
      end
      if (k == int'(WAIT)) nxt_rdy = 1'b1;
      tick();
      cyc++;
    end
    if (rdy === 1'b1 && last_lat < 0) last_lat = cyc;
    if (by_rst && stop_at == int'(WAIT) + 1) begin
      rd = 1'b0;
      wr = 1'b0;
      rst = 1'b1;
      model_reset();
      tick();
      rst = 1'b0;
      return;
    end
    if (w) begin
      if (fifo_m.size() < int'(DEPTH)) fifo_m.push_back(d);
      else nxt_ovf = 1'b1;
    end else begin
      if (fifo_m.size() > 0) nxt_rdata = fifo_m.pop_front();
      else nxt_unf = 1'b1;
    end
    nxt_count = fifo_m.size();
    tick();
    rd = 1'b0;
    wr = 1'b0;
  endtask

  initial begin
    int op;
    int s;
    int stop;
    int gap;
    bit w;
    bit r;
    bit br;
    logic [WIDTH-1:0] d;

    rst = 1'b1;
    rd = 1'b0;
    wr = 1'b0;
    wdata = '0;
    model_reset();
    tick();
    chk_en = 1'b1;
    rst = 1'b0;
    tick();

    // Basic writes: latency WAIT+2 = 3, count steps 1,2,3.
    xfer(1'b1, 1'b0, 8'h11, -1, 1'b0);
    chk("lat_wr", 32'(last_lat), 32'd3);
    chk("cnt_after_w1", 32'(count), 32'd1);
    xfer(1'b1, 1'b0, 8'h22, -1, 1'b0);
    xfer(1'b1, 1'b0, 8'h33, -1, 1'b0);
    chk("cnt_after_w3", 32'(count), 32'd3);

    // Reads return in order, rdata in the cycle after rdy.
    xfer(1'b0, 1'b1, 8'h00, -1, 1'b0);
    chk("lat_rd", 32'(last_lat), 32'd3);
    chk("rd_11", 32'(rdata), 32'h11);
    chk("cnt_after_r1", 32'(count), 32'd2);
    xfer(1'b0, 1'b1, 8'h00, -1, 1'b0);
    chk("rd_22", 32'(rdata), 32'h22);
    xfer(1'b0, 1'b1, 8'h00, -1, 1'b0);
    chk("rd_33", 32'(rdata), 32'h33);
    chk("empty_after_rd", 32'(empty), 32'd1);
    tick();
    chk("rdata_back_to_0", 32'(rdata), 32'd0);

    // Underflow.
    xfer(1'b0, 1'b1, 8'h00, -1, 1'b0);
    chk("unf_lat", 32'(last_lat), 32'd3);
    chk("unf_rdata", 32'(rdata), 32'd0);
    chk("unf_flag", 32'(err_unf), 32'd1);
    chk("unf_count", 32'(count), 32'd0);

    // Overflow: fifth write still gets rdy, data dropped.
    for (int i = 0; i < 5; i++) xfer(1'b1, 1'b0, 8'hA0 + 8'(i), -1, 1'b0);
    chk("ovf_lat", 32'(last_lat), 32'd3);
    chk("ovf_flag", 32'(err_ovf), 32'd1);
    chk("ovf_count", 32'(count), 32'd4);
    chk("ovf_full", 32'(full), 32'd1);
    for (int i = 0; i < 4; i++) begin
      xfer(1'b0, 1'b1, 8'h00, -1, 1'b0);
      chk("ovf_rd", 32'(rdata), 32'hA0 + 32'(i));
    end

    // Aborts: write dropped in the first and last BUSY cycle.
    xfer(1'b1, 1'b0, 8'h77, 0, 1'b0);
    chk("abort0_nordy", 32'(last_lat), 32'hFFFF_FFFF);
    chk("abort0_count", 32'(count), 32'd0);
    xfer(1'b1, 1'b0, 8'h78, int'(WAIT), 1'b0);
    chk("abort1_nordy", 32'(last_lat), 32'hFFFF_FFFF);
    chk("abort1_count", 32'(count), 32'd0);

    // Both lines high: write wins and err_both is flagged.
    xfer(1'b1, 1'b1, 8'h5A, -1, 1'b0);
    chk("both_count", 32'(count), 32'd1);
    chk("both_flag", 32'(err_both), 32'd1);
    xfer(1'b0, 1'b1, 8'h00, -1, 1'b0);
    chk("both_rd", 32'(rdata), 32'h5A);

    // Reset mid-BUSY discards the transfer and clears everything.
    xfer(1'b1, 1'b0, 8'h99, 0, 1'b0);
    xfer(1'b1, 1'b0, 8'h44, -1, 1'b0);
    xfer(1'b1, 1'b0, 8'h99, 1, 1'b1);
    chk("rst_nordy", 32'(rdy), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_errs", 32'({err_ovf, err_unf, err_both}), 32'd0);
    tick();
    chk("rst_nordy2", 32'(rdy), 32'd0);

    // Six round trips across the pointer wrap.
    for (int i = 0; i < 6; i++) begin
      d = 8'hC0 + 8'(i * 3);
      xfer(1'b1, 1'b0, d, -1, 1'b0);
      xfer(1'b0, 1'b1, 8'h00, -1, 1'b0);
      chk("wrap_rd", 32'(rdata), 32'(d));
    end

    // Randomized traffic: mixed ops, occasional both-high, aborts, resets and idle gaps.
    for (int i = 0; i < 400; i++) begin
      op = int'($urandom_range(0, 9));
      w = (op < 5);
      r = (op >= 4);
      s = int'($urandom_range(0, 19));
      stop = -1;
      br = 1'b0;
      if (s == 0) begin
        stop = int'($urandom_range(0, WAIT));
      end else if (s == 1) begin
        stop = int'($urandom_range(0, WAIT + 1));
        br = 1'b1;
      end
      xfer(w, r, WIDTH'($urandom), stop, br);
      gap = int'($urandom_range(0, 2));
      repeat (gap) tick();
    end

    tick();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
